// File: rtl/div_clk_scheduler.sv
// Programmable clock-enable scheduler: divides clk by a runtime ratio with glitch-free reconfiguration.
// Optional feature: define TICK_COUNT_EN to add the saturating tick_count output.
module div_clk_scheduler #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_err,
  output logic             tick,
  output logic             salida
`ifdef TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pendDiv_q, pendDiv_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             salida_q, salida_d;
  logic             cfgReady_q, cfgReady_d;
  logic             cfgErr_q, cfgErr_d;
  logic             xfer;
  logic             divOk;
  logic             wrap;
  logic             running;

  // Outputs are precomputed from the next count and next ratio so that the
  // registered tick lands exactly in the cycle where cnt == N-1.
  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    pendDiv_d = pendDiv_q;
    cnt_d     = cnt_q;
    xfer      = cfg_valid && cfgReady_q;
    divOk     = (cfg_div >= TWO);
    wrap      = (cnt_q == (ratio_q - ONE));
    cfgErr_d  = xfer && !divOk;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && divOk) ratio_d = cfg_div;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (xfer && divOk) ratio_d = cfg_div;
        end else begin
          cnt_d = wrap ? '0 : (cnt_q + ONE);
          if (xfer && divOk) begin
            if (wrap) begin
              ratio_d = cfg_div;
            end else begin
              pendDiv_d = cfg_div;
              state_d   = PEND;
            end
          end
        end
      end
      PEND: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          ratio_d = pendDiv_q;
        end else if (wrap) begin
          state_d = RUN;
          cnt_d   = '0;
          ratio_d = pendDiv_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    running    = (state_d != IDLE);
    tick_d     = running && (cnt_d == (ratio_d - ONE));
    salida_d   = running && (cnt_d >= (ratio_d >> 1));
    cfgReady_d = (state_d != PEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ratio_q    <= DIV_INIT;
      pendDiv_q  <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      salida_q   <= 1'b0;
      cfgReady_q <= 1'b1;
      cfgErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pendDiv_q  <= pendDiv_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      salida_q   <= salida_d;
      cfgReady_q <= cfgReady_d;
      cfgErr_q   <= cfgErr_d;
    end
  end

  assign tick      = tick_q;
  assign salida    = salida_q;
  assign cfg_ready = cfgReady_q;
  assign cfg_err   = cfgErr_q;

`ifdef TICK_COUNT_EN
  logic [15:0] tickCount_q;

  // Counts completed periods; cleared whenever the scheduler is idle.
  always_ff @(posedge clk) begin
    if (reset || (state_d == IDLE)) begin
      tickCount_q <= '0;
    end else if (tick_q && (tickCount_q != 16'hFFFF)) begin
      tickCount_q <= tickCount_q + 16'd1;
    end
  end

  assign tick_count = tickCount_q;
`endif

endmodule
